inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Avalon-MM master that fills a single-port on-chip instruction/data memory from a 32-bit Avalon-ST word stream (the FIFO output) and can read it back to verify it.
- It drives the slave port of the 16K x 32 on-chip RAM, with 14-bit word addressing, 4-bit byteenable and fixed read latency.
- The NIOS or test logic triggers a load using start, base_addr and word_count.
- The block reports busy, a done pulse, a sticky error flag and a 32-bit additive checksum.

Parameters:
- ADDR_W, 14, word-address width of the target memory.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed number of cycles from an accepted read command to valid avm_readdata.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on start.
- word_count  in  ADDR_W+1  number of words to load (0 to 2^ADDR_W); latched on start.
- verify_en  in  1  run the read-back pass after writing; latched on start.
- snk_data  in  DATA_W  stream word.
- snk_valid  in  1  stream word valid.
- snk_ready  out  1  loader accepts the stream word this cycle.
- avm_address  out  ADDR_W  memory word address.
- avm_byteenable  out  DATA_W/8  byte enables.
- avm_chipselect  out  1  bus select.
- avm_write  out  1  write command.
- avm_read  out  1  read command.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data.
- avm_waitrequest  in  1  slave stall; 0 if the slave never stalls.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky verify mismatch.
- checksum  out  DATA_W  sum of the written words, modulo 2^DATA_W.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: every output is 0 and state is IDLE. Assertion of reset_n mid-operation aborts immediately; bus commands drop and no done is issued.
- States: IDLE, WR_ACCEPT, WR_BUS, RD_CMD, RD_WAIT, CHECK, DONE.
- IDLE, on start:
  - latch the inputs; addr=base_addr; remaining=word_count.
  - clear checksum, the verify sum and error; busy=1.
  - word_count=0: go to DONE with no bus activity and checksum=0.
  - Otherwise go to WR_ACCEPT.
- WR_ACCEPT:
  - snk_ready=1; no bus command is active.
  - On snk_valid: capture snk_data into avm_writedata and go to WR_BUS.
- WR_BUS:
  - avm_chipselect=1, avm_write=1, avm_byteenable=all ones; address and data held stable while avm_waitrequest=1.
  - On the cycle with waitrequest=0: checksum+=word, addr+=1 (wraps modulo 2^ADDR_W), remaining-=1.
  - Next state: remaining=0 and verify_en gives RD_CMD with addr reloaded to base_addr and remaining reloaded; remaining=0 without verify_en gives DONE; otherwise WR_ACCEPT.
  - Maximum write rate is 1 word per 2 cycles.
- RD_CMD:
  - avm_chipselect=1, avm_read=1, address=addr, held while waitrequest=1.
  - When accepted, deassert read/chipselect the next cycle and go to RD_WAIT.
- RD_WAIT:
  - Counts READ_LATENCY cycles from acceptance, then samples avm_readdata into vsum+=data.
  - Then addr+=1, remaining-=1.
  - Next state: RD_CMD if remaining>0, else CHECK.
- CHECK: error=1 if vsum!=checksum; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
- Status hold: error and checksum hold until the next start.
- Outside phases: snk_ready=0 outside WR_ACCEPT. start is ignored while busy.
- Checksum width rule: DATA_W-bit unsigned addition; carries are discarded.

Test Plan:
- base=0x0010, count=4, verify_en=0, stream 0x11,0x22,0x33,0x44, waitrequest=0:
  - 4 writes at addresses 0x10–0x13 with byteenable=0xF.
  - checksum=0xAA; done pulses once; busy falls in the same cycle; no reads occur.
- Same load with verify_en=1 and a memory model:
  - 4 reads at 0x10–0x13, each with 1-cycle latency.
  - error=0; done follows the CHECK cycle.
- Verify with the memory model corrupting address 0x12 (returns 0x34): error=1 and done pulses.
- base=0x3FFE, count=4:
  - writes go to 0x3FFE, 0x3FFF, 0x0000, 0x0001.
  - Stream 0xFFFFFFFF x4 gives checksum=0xFFFFFFFC.
- Back-pressure and stalls:
  - Random snk_valid gaps plus 3-cycle waitrequest bursts on writes and reads.
  - Address and data stay stable during stalls; no word is lost or duplicated; checksum is correct.
- Edge cases:
  - count=0: done 1 cycle after start with no bus activity.
  - reset_n low during WR_BUS: all outputs are 0 immediately.
  - After release: IDLE; a new start works.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Avalon-MM master: loads a word stream into on-chip RAM, optionally reads it back and compares additive checksums.
// Latency: 2 cycles per written word and 1+READ_LATENCY per read word; the stream stalls while a write waits on waitrequest.
module inst_mem_loader #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic                  verify_en,
  input  logic [DATA_W-1:0]     snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     checksum
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;
  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ACCEPT,
    WR_BUS,
    RD_CMD,
    RD_WAIT,
    CHECK,
    DONE
  } state_t;

  state_t              state;
  state_t              state_n;

  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    count_q;
  logic                verify_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [DATA_W-1:0]   vsum_q;
  logic                error_q;
  logic [LAT_W-1:0]    lat_cnt_q;

  logic                last_word;
  logic                lat_hit;

  assign last_word = (remaining_q == CNT_W'(1));
  assign lat_hit   = (lat_cnt_q >= LAT_W'(READ_LATENCY));

  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign error         = error_q;
  assign checksum      = checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    snk_ready      = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    avm_byteenable = '0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_n = (word_count == '0) ? DONE : WR_ACCEPT;
        end
      end
      WR_ACCEPT: begin
        snk_ready = 1'b1;
        if (snk_valid) begin
          state_n = WR_BUS;
        end
      end
      WR_BUS: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = {BE_W{1'b1}};
        if (!avm_waitrequest) begin
          if (last_word) begin
            state_n = verify_q ? RD_CMD : DONE;
          end else begin
            state_n = WR_ACCEPT;
          end
        end
      end
      RD_CMD: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_byteenable = {BE_W{1'b1}};
        if (!avm_waitrequest) begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_hit) begin
          state_n = last_word ? CHECK : RD_CMD;
        end
      end
      CHECK: begin
        state_n = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address and count registers are shared by the write and read-back passes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      count_q     <= '0;
      verify_q    <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      wdata_q     <= '0;
      checksum_q  <= '0;
      vsum_q      <= '0;
      error_q     <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            count_q     <= word_count;
            verify_q    <= verify_en;
            addr_q      <= base_addr;
            remaining_q <= word_count;
            checksum_q  <= '0;
            vsum_q      <= '0;
            error_q     <= 1'b0;
          end
        end
        WR_ACCEPT: begin
          if (snk_valid) begin
            wdata_q <= snk_data;
          end
        end
        WR_BUS: begin
          if (!avm_waitrequest) begin
            checksum_q <= checksum_q + wdata_q;
            if (last_word && verify_q) begin
              addr_q      <= base_q;
              remaining_q <= count_q;
            end else begin
              addr_q      <= addr_q + ADDR_W'(1);
              remaining_q <= remaining_q - CNT_W'(1);
            end
          end
        end
        RD_CMD: begin
          if (!avm_waitrequest) begin
            lat_cnt_q <= LAT_W'(1);
          end
        end
        RD_WAIT: begin
          if (lat_hit) begin
            vsum_q      <= vsum_q + avm_readdata;
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        CHECK: begin
          error_q <= (vsum_q != checksum_q);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with an Avalon slave RAM model, optional waitrequest bursts and read corruption.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] word_count;
  logic        verify_en;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic [13:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  inst_mem_loader #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .verify_en(verify_en), .snk_data(snk_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model: every command stalls for 3 cycles when stall_en is set.
  logic        stall_en;
  logic        corrupt_en;
  logic [13:0] corrupt_addr;
  logic [1:0]  stall_cnt;
  logic [31:0] mem [0:16383];

  assign avm_waitrequest = stall_en && avm_chipselect && (stall_cnt != 2'd3);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= 2'd0;
    else if (avm_chipselect && avm_waitrequest) stall_cnt <= stall_cnt + 2'd1;
    else stall_cnt <= 2'd0;
  end

  always @(posedge clk) begin
    if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    if (avm_chipselect && avm_read && !avm_waitrequest)
      avm_readdata <= (corrupt_en && avm_address == corrupt_addr) ? 32'h34 : mem[avm_address];
  end

  logic [13:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [13:0] rd_a[$];
  logic [31:0] stim_q[$];
  int          done_cnt = 0;
  int          bus_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [2:0]  prev_cmd;

  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_chipselect || avm_write || avm_read) bus_cnt++;
      if (avm_chipselect && avm_write && !avm_waitrequest) begin
        wr_a.push_back(avm_address);
        wr_d.push_back(avm_writedata);
        chk("wr_byteenable", avm_byteenable, 4'hF);
      end
      if (avm_chipselect && avm_read && !avm_waitrequest) rd_a.push_back(avm_address);
      if (done) begin
        done_cnt++;
        chk("busy_with_done", busy, 0);
      end
      if (prev_stall) begin
        chk("stall_addr", avm_address, prev_addr);
        chk("stall_cmd", {avm_chipselect, avm_write, avm_read}, prev_cmd);
        if (prev_cmd[1]) chk("stall_wdata", avm_writedata, prev_wdata);
      end
      prev_stall = avm_chipselect && avm_waitrequest;
      prev_addr  = avm_address;
      prev_wdata = avm_writedata;
      prev_cmd   = {avm_chipselect, avm_write, avm_read};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_idle(input string t);
    chk({t, "_bus"}, {avm_chipselect, avm_write, avm_read, avm_byteenable}, 0);
    chk({t, "_addr"}, avm_address, 0);
    chk({t, "_wdata"}, avm_writedata, 0);
    chk({t, "_status"}, {snk_ready, busy, done, error}, 0);
    chk({t, "_checksum"}, checksum, 0);
  endtask

  task automatic do_start(input logic [13:0] b, input logic [14:0] n, input logic v);
    @(posedge clk); #1;
    base_addr = b; word_count = n; verify_en = v; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) begin snk_valid = 1'b0; @(posedge clk); #1; end
    snk_valid = 1'b1; snk_data = w;
    n = 0;
    do begin @(negedge clk); n++; end while (!snk_ready && n < 500);
    if (!snk_ready) chk("stream_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [13:0] b, input logic [14:0] n, input logic v,
                          input int maxgap, output int lat, output int dones, output int bus);
    int d0, b0, k, dcyc;
    bit got;
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    d0 = done_cnt; b0 = bus_cnt;
    do_start(b, n, v);
    for (int i = 0; i < int'(n); i++)
      push_word(stim_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    snk_valid = 1'b0;
    got = 0; k = 0; dcyc = 0;
    while (!got && k < 3000) begin
      @(negedge clk); k++;
      if (done) begin got = 1; dcyc = cyc; end
    end
    if (!got) chk("done_timeout", 0, 1);
    lat = dcyc - start_cyc;
    repeat (3) @(negedge clk);
    dones = done_cnt - d0;
    bus = bus_cnt - b0;
  endtask

  task automatic check_writes(input string t, input logic [13:0] b, input int n);
    logic [13:0] a;
    chk({t, "_wr_count"}, wr_a.size(), n);
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      a = b + 14'(i);
      chk({t, "_wr_addr"}, wr_a[i], a);
      chk({t, "_wr_data"}, wr_d[i], stim_q[i]);
    end
  endtask

  task automatic check_reads(input string t, input logic [13:0] b, input int n);
    logic [13:0] a;
    chk({t, "_rd_count"}, rd_a.size(), n);
    for (int i = 0; i < n && i < rd_a.size(); i++) begin
      a = b + 14'(i);
      chk({t, "_rd_addr"}, rd_a[i], a);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, dones, bus, n;
    logic [31:0] sum;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; verify_en = 1'b0;
    snk_data = '0; snk_valid = 1'b0; stall_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (3) @(posedge clk); #1;
    check_idle("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_idle("post_reset");

    // Plain load, no verify.
    stim_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_load(14'h0010, 15'd4, 1'b0, 0, lat, dones, bus);
    check_writes("t1", 14'h0010, 4);
    chk("t1_reads", rd_a.size(), 0);
    chk("t1_checksum", checksum, 32'hAA);
    chk("t1_error", error, 0);
    chk("t1_latency", lat, 9);
    chk("t1_done_once", dones, 1);

    // Same load with read-back.
    run_load(14'h0010, 15'd4, 1'b1, 0, lat, dones, bus);
    check_writes("t2", 14'h0010, 4);
    check_reads("t2", 14'h0010, 4);
    chk("t2_checksum", checksum, 32'hAA);
    chk("t2_error", error, 0);
    chk("t2_latency", lat, 18);
    chk("t2_done_once", dones, 1);

    // Read-back corrupted at 0x12.
    corrupt_en = 1'b1; corrupt_addr = 14'h0012;
    run_load(14'h0010, 15'd4, 1'b1, 0, lat, dones, bus);
    corrupt_en = 1'b0;
    chk("t3_error", error, 1);
    chk("t3_checksum", checksum, 32'hAA);
    chk("t3_done_once", dones, 1);

    // Zero-length load clears status and touches no bus.
    run_load(14'h0055, 15'd0, 1'b1, 0, lat, dones, bus);
    chk("t4_latency", lat, 1);
    chk("t4_bus_cycles", bus, 0);
    chk("t4_checksum", checksum, 0);
    chk("t4_error", error, 0);
    chk("t4_done_once", dones, 1);

    // Address wrap and checksum carry discard.
    stim_q = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_load(14'h3FFE, 15'd4, 1'b1, 0, lat, dones, bus);
    check_writes("t5", 14'h3FFE, 4);
    check_reads("t5", 14'h3FFE, 4);
    chk("t5_wrap_addr2", (wr_a.size() > 2) ? wr_a[2] : 14'h3FFF, 14'h0000);
    chk("t5_checksum", checksum, 32'hFFFFFFFC);
    chk("t5_error", error, 0);

    // Stream gaps plus 3-cycle waitrequest bursts on every command.
    stall_en = 1'b1;
    stim_q = '{32'h01020304, 32'hDEADBEEF, 32'h80000000, 32'h80000001, 32'h12345678, 32'h00000007};
    sum = '0;
    foreach (stim_q[i]) sum = sum + stim_q[i];
    run_load(14'h0200, 15'd6, 1'b1, 3, lat, dones, bus);
    stall_en = 1'b0;
    check_writes("t6", 14'h0200, 6);
    check_reads("t6", 14'h0200, 6);
    chk("t6_checksum", checksum, sum);
    chk("t6_error", error, 0);
    chk("t6_done_once", dones, 1);

    // Reset in the middle of a stalled write.
    stall_en = 1'b1;
    do_start(14'h0100, 15'd3, 1'b0);
    snk_valid = 1'b1; snk_data = 32'hCAFEF00D;
    n = 0;
    while (!(avm_chipselect && avm_write) && n < 20) begin @(negedge clk); n++; end
    chk("t7_reach_wr_bus", avm_chipselect && avm_write, 1);
    n = done_cnt;
    reset_n = 1'b0;
    #1;
    check_idle("t7_in_reset");
    snk_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1; stall_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_idle("t7_after_release");
    chk("t7_no_done", done_cnt - n, 0);

    stim_q = '{32'h5, 32'h6};
    run_load(14'h0020, 15'd2, 1'b1, 0, lat, dones, bus);
    check_writes("t8", 14'h0020, 2);
    check_reads("t8", 14'h0020, 2);
    chk("t8_checksum", checksum, 32'hB);
    chk("t8_error", error, 0);
    chk("t8_done_once", dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
